// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_pkg.sv
// Shared types and helpers for the scan-chain sequencer.
package gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT_IN  = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_SHIFT_OUT = 2'd3
    } state_t;

    // Counter must hold the longest per-state edge count without wrapping.
    function automatic int cnt_width(input int chain_len, input int capture_cycles);
        int m;
        m = (chain_len > capture_cycles) ? chain_len : capture_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_shreg.sv
// W-bit shift register: parallel load, shifts toward the MSB, serial input at the LSB.
module gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    input  logic         sin,
    output logic [W-1:0] q
);

    // Load has priority over shift; both are single-cycle strobes from the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {q[W-2:0], sin};
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_ctrl.sv
// Scan-chain sequencer: shift a pattern into the chain, capture, shift the response out.
module gf180mcu_fd_sc_mcu9t5v0__scan_ctrl
    import gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN      = 8,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP_OUT
);

    localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                se_n, si_n, done_n, busy_n;
    logic                pat_load, pat_shift, resp_shift, resp_upd;
    logic [CHAIN_LEN-1:0] pat_q, resp_q;
    logic                unused_bits;

    // Pattern shadow: SI for edge e0 comes straight from PAT_IN, later bits from here.
    gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_shreg #(.W(CHAIN_LEN)) u_pat (
        .clk   (CLK),
        .rst   (RST),
        .load  (pat_load),
        .shift (pat_shift),
        .din   (PAT_IN),
        .sin   (1'b0),
        .q     (pat_q)
    );

    // Response assembly: first SO sample migrates up to the MSB.
    gf180mcu_fd_sc_mcu9t5v0__scan_ctrl_shreg #(.W(CHAIN_LEN)) u_resp (
        .clk   (CLK),
        .rst   (RST),
        .load  (1'b0),
        .shift (resp_shift),
        .din   ('0),
        .sin   (SO),
        .q     (resp_q)
    );

    // The pattern MSB is consumed directly from PAT_IN, and the response MSB
    // is overwritten by the final SO sample, so neither is read from the registers.
    assign unused_bits = pat_q[CHAIN_LEN-1] ^ resp_q[CHAIN_LEN-1];

    // State, counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            SE       <= 1'b0;
            SI       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESP_OUT <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            SE    <= se_n;
            SI    <= si_n;
            BUSY  <= busy_n;
            DONE  <= done_n;
            if (resp_upd)
                RESP_OUT <= {resp_q[CHAIN_LEN-2:0], SO};
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        se_n       = SE;
        si_n       = 1'b0;
        done_n     = 1'b0;
        pat_load   = 1'b0;
        pat_shift  = 1'b0;
        resp_shift = 1'b0;
        resp_upd   = 1'b0;

        case (state)
            ST_IDLE: begin
                se_n  = 1'b0;
                cnt_n = '0;
                if (START && !ABORT) begin
                    pat_load = 1'b1;
                    se_n     = 1'b1;
                    si_n     = PAT_IN[CHAIN_LEN-1];
                    state_n  = ST_SHIFT_IN;
                end
            end
            ST_SHIFT_IN: begin
                pat_shift = 1'b1;
                se_n      = 1'b1;
                si_n      = pat_q[CHAIN_LEN-2];
                if (cnt == SHIFT_LAST) begin
                    se_n    = 1'b0;
                    si_n    = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                se_n = 1'b0;
                if (cnt == CAP_LAST) begin
                    se_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_SHIFT_OUT;
                end
            end
            ST_SHIFT_OUT: begin
                se_n       = 1'b1;
                resp_shift = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    resp_upd = 1'b1;
                    done_n   = 1'b1;
                    se_n     = 1'b0;
                    cnt_n    = '0;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                se_n    = 1'b0;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase

        if (ABORT && state != ST_IDLE) begin
            state_n    = ST_IDLE;
            cnt_n      = '0;
            se_n       = 1'b0;
            si_n       = 1'b0;
            done_n     = 1'b0;
            pat_shift  = 1'b0;
            resp_shift = 1'b0;
            resp_upd   = 1'b0;
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule
